fifo_stream_reader: RTL

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// ----------------------------------------------------------------------------
// fifo_stream_reader
//
// Pulls words out of an upstream synchronous-read FIFO and presents them as a
// valid/ready stream. Read data arrives one cycle after the read strobe, so
// the block tracks one in-flight read and only issues a strobe when the
// buffer is guaranteed to have room for the returning word. With words
// available and the consumer always ready, one word is delivered per cycle.
//
// Parameters
//   WIDTH      data width in bits (>= 1)
//   DEPTH      output buffer entries (>= 2, need not be a power of two)
//   CNT_WIDTH  width of the delivered-word counter
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-low reset
//   rdena      read strobe to the upstream FIFO
//   rddata     upstream read data, valid the cycle after rdena was high
//   empty      upstream FIFO empty flag
//   flush      synchronous discard of buffered and in-flight words
//   out_valid  out_data holds a word
//   out_data   head word of the output buffer
//   out_ready  consumer accepts the word when out_valid is high
//   count      number of completed output transfers, wrapping
// ----------------------------------------------------------------------------
module fifo_stream_reader #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 rdena,
  input  logic [WIDTH-1:0]     rddata,
  input  logic                 empty,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] buf_mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [OCC_W-1:0] occ;
  logic             inflight;
  logic             run;

  logic             pop_req;
  logic             pop;
  logic             capture;
  logic [OCC_W:0]   demand;
  logic [OCC_W:0]   limit;

  // Circular pointer advance; explicit wrap so non power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // ---- stage 0: read request -------------------------------------------
  // A strobe is only safe if every word already committed (buffered plus the
  // one in flight), less the one leaving this cycle, leaves a free slot.
  // The comparison is rearranged as occ + inflight < DEPTH + pop so that it
  // stays unsigned without an underflow case.
  assign pop_req = out_valid & out_ready;
  assign demand  = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
  assign limit   = (OCC_W + 1)'(DEPTH) + {{OCC_W{1'b0}}, pop_req};
  assign rdena   = run & ~empty & ~flush & (demand < limit);

  // ---- stage 1: returning read data, buffer and output -----------------
  // A flush cancels both the capture of the returning word and any pop, so
  // the counter does not advance in a flush cycle.
  assign capture   = inflight & ~flush;
  assign pop       = pop_req & ~flush;
  assign out_valid = (occ != '0);
  assign out_data  = buf_mem[head];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run      <= 1'b0;
      inflight <= 1'b0;
    end else begin
      // run holds rdena low for the first cycle after reset release
      run      <= 1'b1;
      inflight <= rdena;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_mem[i] <= '0;
      end
    end else if (flush) begin
      // tail is not moved by a flush, so collapsing head onto it empties
      // the buffer without touching storage
      head <= tail;
      occ  <= '0;
    end else begin
      if (capture) begin
        buf_mem[tail] <= rddata;
        tail          <= ptr_inc(tail);
      end
      if (pop) begin
        head <= ptr_inc(head);
      end
      case ({capture, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (pop) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule
